// File: rtl/ptp_slave_xchg_if.sv
// Event/strobe bundle between the PTP packet parser, the slave exchange
// sequencer and the offset block. master = event source side, slave = sequencer.
interface ptp_slave_xchg_if;
    logic        m_or_s;
    logic        sync_rx;
    logic [47:0] sync_ts;
    logic [15:0] sync_seq;
    logic        dreq_tx_done;
    logic [47:0] dreq_tx_ts;
    logic        dresp_rx;
    logic [47:0] dresp_ts;
    logic [15:0] dresp_seq;

    logic        send_delay_req;
    logic [15:0] dreq_seq;
    logic        ts_2_record;
    logic        ts_1_valid;
    logic [47:0] ts_1;
    logic        ts_3_valid;
    logic [47:0] ts_3;
    logic        ts_4_valid;
    logic [47:0] ts_4;
    logic        status_ok;
    logic        timeout;
    logic        bad_ts;
    logic [31:0] xchg_cnt;

    modport master (
        output m_or_s, sync_rx, sync_ts, sync_seq, dreq_tx_done, dreq_tx_ts,
               dresp_rx, dresp_ts, dresp_seq,
        input  send_delay_req, dreq_seq, ts_2_record, ts_1_valid, ts_1,
               ts_3_valid, ts_3, ts_4_valid, ts_4, status_ok, timeout, bad_ts, xchg_cnt
    );

    modport slave (
        input  m_or_s, sync_rx, sync_ts, sync_seq, dreq_tx_done, dreq_tx_ts,
               dresp_rx, dresp_ts, dresp_seq,
        output send_delay_req, dreq_seq, ts_2_record, ts_1_valid, ts_1,
               ts_3_valid, ts_3, ts_4_valid, ts_4, status_ok, timeout, bad_ts, xchg_cnt
    );
endinterface

// File: rtl/ptp_slave_xchg.sv
// Slave-side PTP Sync / Delay_Req / Delay_Resp sequencer producing t1..t4 strobes.
// Define PTP_SEQ_CHECK_EN to accept Delay_Resp only when its sequenceId matches.
module ptp_slave_xchg #(
    parameter int TIMEOUT_CYC = 125000,
    parameter int CYC_MAX     = 124999,
    parameter int OK_GAP      = 2
) (
    input  logic             clk,
    input  logic             reset,
    ptp_slave_xchg_if.slave  io_xchg
);
    localparam int CNT_TOP = (TIMEOUT_CYC > OK_GAP) ? TIMEOUT_CYC : OK_GAP;
    localparam int CNT_W   = $clog2(CNT_TOP + 1);
    localparam logic [16:0]      CYC_LIM  = 17'(CYC_MAX);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(OK_GAP - 1);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT_TX, S_WAIT_RESP, S_GAP} state_t;

    state_t           r_state, w_state;
    logic [CNT_W-1:0] r_cnt, w_cnt;
    logic             r_send, w_send, r_ts2, w_ts2, r_ts1v, w_ts1v;
    logic             r_ts3v, w_ts3v, r_ts4v, w_ts4v;
    logic             r_ok, w_ok, r_to, w_to, r_bad, w_bad;
    logic [15:0]      r_dreq_seq, w_dreq_seq;
    logic [47:0]      r_ts1, w_ts1, r_ts3, w_ts3, r_ts4, w_ts4;
    logic [31:0]      r_xcnt, w_xcnt;

    logic w_sync_ok, w_tx_ok, w_rx_ok, w_seq_ok, w_expired;

    assign w_sync_ok = io_xchg.sync_ts[16:0]    <= CYC_LIM;
    assign w_tx_ok   = io_xchg.dreq_tx_ts[16:0] <= CYC_LIM;
    assign w_rx_ok   = io_xchg.dresp_ts[16:0]   <= CYC_LIM;
    assign w_expired = r_cnt == TO_LAST;
`ifdef PTP_SEQ_CHECK_EN
    assign w_seq_ok  = io_xchg.dresp_seq == r_dreq_seq;
`else
    assign w_seq_ok  = 1'b1;
`endif

    // NOTE: every signal driven here gets a default first, so no path infers a latch.
    always_comb begin
        w_state    = r_state;
        w_send     = 1'b0;
        w_ts2      = 1'b0;
        w_ts1v     = 1'b0;
        w_ts3v     = 1'b0;
        w_ts4v     = 1'b0;
        w_ok       = 1'b0;
        w_to       = 1'b0;
        w_bad      = 1'b0;
        w_ts1      = r_ts1;
        w_ts3      = r_ts3;
        w_ts4      = r_ts4;
        w_dreq_seq = r_dreq_seq;
        w_xcnt     = r_xcnt;

        if (io_xchg.m_or_s) begin
            w_state = S_IDLE;
        end else if (io_xchg.sync_rx && w_sync_ok) begin
            // A good Sync restarts the exchange from any state and beats a coincident timeout.
            w_ts2      = 1'b1;
            w_ts1v     = 1'b1;
            w_ts1      = io_xchg.sync_ts;
            w_dreq_seq = io_xchg.sync_seq;
            w_state    = S_REQ;
        end else begin
            w_bad = io_xchg.sync_rx;
            case (r_state)
                S_REQ: begin
                    w_send  = 1'b1;
                    w_state = S_WAIT_TX;
                end
                S_WAIT_TX: begin
                    if (io_xchg.dreq_tx_done && w_tx_ok) begin
                        w_ts3v  = 1'b1;
                        w_ts3   = io_xchg.dreq_tx_ts;
                        w_state = S_WAIT_RESP;
                    end else begin
                        if (io_xchg.dreq_tx_done) w_bad = 1'b1;
                        if (w_expired) begin
                            w_to    = 1'b1;
                            w_state = S_IDLE;
                        end
                    end
                end
                S_WAIT_RESP: begin
                    if (io_xchg.dresp_rx && w_rx_ok && w_seq_ok) begin
                        w_ts4v  = 1'b1;
                        w_ts4   = io_xchg.dresp_ts;
                        w_state = S_GAP;
                    end else begin
                        if (io_xchg.dresp_rx && !w_rx_ok) w_bad = 1'b1;
                        if (w_expired) begin
                            w_to    = 1'b1;
                            w_state = S_IDLE;
                        end
                    end
                end
                S_GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        w_ok    = 1'b1;
                        w_xcnt  = r_xcnt + 32'd1;
                        w_state = S_IDLE;
                    end
                end
                default: ;
            endcase
        end

        // Every counted state is entered from a different state, so a state change clears it.
        w_cnt = (w_state != r_state || r_state == S_IDLE) ? '0 : r_cnt + CNT_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_send     <= 1'b0;
            r_ts2      <= 1'b0;
            r_ts1v     <= 1'b0;
            r_ts3v     <= 1'b0;
            r_ts4v     <= 1'b0;
            r_ok       <= 1'b0;
            r_to       <= 1'b0;
            r_bad      <= 1'b0;
            r_dreq_seq <= '0;
            r_ts1      <= '0;
            r_ts3      <= '0;
            r_ts4      <= '0;
            r_xcnt     <= '0;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_send     <= w_send;
            r_ts2      <= w_ts2;
            r_ts1v     <= w_ts1v;
            r_ts3v     <= w_ts3v;
            r_ts4v     <= w_ts4v;
            r_ok       <= w_ok;
            r_to       <= w_to;
            r_bad      <= w_bad;
            r_dreq_seq <= w_dreq_seq;
            r_ts1      <= w_ts1;
            r_ts3      <= w_ts3;
            r_ts4      <= w_ts4;
            r_xcnt     <= w_xcnt;
        end
    end

    assign io_xchg.send_delay_req = r_send;
    assign io_xchg.dreq_seq       = r_dreq_seq;
    assign io_xchg.ts_2_record    = r_ts2;
    assign io_xchg.ts_1_valid     = r_ts1v;
    assign io_xchg.ts_1           = r_ts1;
    assign io_xchg.ts_3_valid     = r_ts3v;
    assign io_xchg.ts_3           = r_ts3;
    assign io_xchg.ts_4_valid     = r_ts4v;
    assign io_xchg.ts_4           = r_ts4;
    assign io_xchg.status_ok      = r_ok;
    assign io_xchg.timeout        = r_to;
    assign io_xchg.bad_ts         = r_bad;
    assign io_xchg.xchg_cnt       = r_xcnt;
endmodule
